// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS subset core: FETCH/DECODE/EXEC/MEM/WB FSM sharing one
// instruction/data memory port with a valid/ready handshake.
module mips_multicycle_core #(
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  output logic                  halted,
  output logic                  fault,
  output logic [31:0]           dbg_pc
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;
  typedef enum logic [2:0] {K_ALU, K_ADDI, K_LW, K_SW, K_BEQ, K_BNE, K_J} kind_e;

  state_e      state;
  kind_e       kind;
  logic [31:0] pc, ir, a_q, b_q, alu_out, mdr;
  logic        fault_q;
  logic [31:0] rf [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sx;

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign funct  = ir[5:0];
  assign imm_sx = {{16{ir[15]}}, ir[15:0]};

  logic  dec_legal;
  kind_e dec_kind;

  always_comb begin
    dec_legal = 1'b1;
    dec_kind  = K_ALU;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A: dec_kind = K_ALU;
          default: dec_legal = 1'b0;
        endcase
      end
      6'h08:   dec_kind = K_ADDI;
      6'h23:   dec_kind = K_LW;
      6'h2B:   dec_kind = K_SW;
      6'h04:   dec_kind = K_BEQ;
      6'h05:   dec_kind = K_BNE;
      6'h02:   dec_kind = K_J;
      default: dec_legal = 1'b0;
    endcase
  end

  // Non-R-type kinds all use A + sext(imm) (addi and effective address).
  logic [31:0] alu_y;

  always_comb begin
    alu_y = a_q + imm_sx;
    if (kind == K_ALU) begin
      case (funct)
        6'h22, 6'h23: alu_y = a_q - b_q;
        6'h24:        alu_y = a_q & b_q;
        6'h25:        alu_y = a_q | b_q;
        6'h27:        alu_y = ~(a_q | b_q);
        6'h2A:        alu_y = {31'd0, $signed(a_q) < $signed(b_q)};
        default:      alu_y = a_q + b_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_FETCH;
      kind    <= K_ALU;
      pc      <= RESET_PC;
      ir      <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_out <= '0;
      mdr     <= '0;
      fault_q <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_ready) begin
            ir    <= mem_rdata;
            pc    <= pc + 32'd4;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_q  <= rf[rs];
          b_q  <= rf[rt];
          kind <= dec_kind;
          if (ir == 32'h0000_000C) begin
            state <= S_HALT;
          end else if (!dec_legal) begin
            fault_q <= 1'b1;
            state   <= S_HALT;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (kind)
            K_ALU, K_ADDI: begin
              alu_out <= alu_y;
              state   <= S_WB;
            end
            K_LW, K_SW: begin
              alu_out <= alu_y;
              if (alu_y[1:0] != 2'b00) begin
                fault_q <= 1'b1;
                state   <= S_HALT;
              end else begin
                state <= S_MEM;
              end
            end
            K_BEQ, K_BNE: begin
              // pc already points past the branch, so the offset is relative to it
              if ((a_q == b_q) == (kind == K_BEQ))
                pc <= pc + {imm_sx[29:0], 2'b00};
              state <= S_FETCH;
            end
            default: begin
              pc    <= {pc[31:28], ir[25:0], 2'b00};
              state <= S_FETCH;
            end
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            if (kind == K_LW) begin
              mdr   <= mem_rdata;
              state <= S_WB;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        S_WB:    state <= S_FETCH;
        default: state <= S_HALT;
      endcase
    end
  end

  logic [4:0]  wb_dst;
  logic [31:0] wb_data;

  assign wb_dst  = (kind == K_ALU) ? rd : rt;
  assign wb_data = (kind == K_LW) ? mdr : alu_out;

  // r0 is never written, so it reads back as zero without a read-side mux.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (state == S_WB && wb_dst != 5'd0) begin
      rf[wb_dst] <= wb_data;
    end
  end

  // Port outputs decode the registered state; gating with rst drops a
  // pending request in the same cycle reset is asserted.
  logic [31:0] req_addr;

  assign req_addr  = (state == S_MEM) ? alu_out : pc;
  assign mem_req   = rst && (state == S_FETCH || state == S_MEM);
  assign mem_we    = rst && state == S_MEM && kind == K_SW;
  assign mem_addr  = mem_req ? req_addr[ADDR_WIDTH-1:0] : '0;
  assign mem_wdata = mem_we ? b_q : '0;
  assign halted    = (state == S_HALT);
  assign fault     = fault_q;
  assign dbg_pc    = pc;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: instruction-level reference model feeds a
// transaction scoreboard; memory model inserts wait states.
module tb_mips_multicycle_core;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req, mem_we, mem_ready, halted, fault;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, dbg_pc;

  always #5 clk = ~clk;

  mips_multicycle_core #(.ADDR_WIDTH(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .halted(halted), .fault(fault), .dbg_pc(dbg_pc)
  );

  logic [31:0] mem [0:1023];
  assign mem_rdata = mem[mem_addr[11:2]];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {logic we; logic data; logic [31:0] addr; logic [31:0] wdata;} txn_t;

  txn_t        exp_q[$];
  logic [31:0] ref_mem [0:1023];
  int          exp_cyc;
  logic        exp_fault;
  logic [31:0] exp_pc;

  function automatic logic [31:0] sext(input logic [15:0] i);
    return {{16{i[15]}}, i};
  endfunction

  function automatic logic [31:0] r_(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic put(input logic [31:0] addr, input logic [31:0] w);
    mem[addr[11:2]] = w;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    for (int i = 128; i < 144; i++) mem[i] = $urandom;
  endtask

  // Architectural model: one instruction per iteration, cycle cost from the
  // published per-instruction counts (halting instruction counted up to the
  // cycle before HALT is entered).
  task automatic iss();
    logic [31:0] r [32];
    logic [31:0] pc, ir, ea, v;
    logic [4:0]  wr;
    bit          done;
    for (int i = 0; i < 32; i++) r[i] = 0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
    pc = RESET_PC; exp_cyc = 0; exp_fault = 0; exp_q.delete(); done = 0;
    for (int step = 0; step < 3000 && !done; step++) begin
      exp_q.push_back('{1'b0, 1'b0, pc, 32'd0});
      ir = ref_mem[pc[11:2]];
      pc = pc + 4;
      wr = 0; v = 0;
      if (ir == 32'h0000_000C) begin
        exp_cyc += 2; done = 1;
      end else begin
        case (ir[31:26])
          6'h00: begin
            wr = ir[15:11];
            exp_cyc += 4;
            case (ir[5:0])
              6'h20, 6'h21: v = r[ir[25:21]] + r[ir[20:16]];
              6'h22, 6'h23: v = r[ir[25:21]] - r[ir[20:16]];
              6'h24: v = r[ir[25:21]] & r[ir[20:16]];
              6'h25: v = r[ir[25:21]] | r[ir[20:16]];
              6'h27: v = ~(r[ir[25:21]] | r[ir[20:16]]);
              6'h2A: v = ($signed(r[ir[25:21]]) < $signed(r[ir[20:16]])) ? 1 : 0;
              default: begin wr = 0; exp_cyc -= 2; exp_fault = 1; done = 1; end
            endcase
          end
          6'h08: begin wr = ir[20:16]; v = r[ir[25:21]] + sext(ir[15:0]); exp_cyc += 4; end
          6'h23: begin
            ea = r[ir[25:21]] + sext(ir[15:0]);
            if (ea[1:0] != 0) begin exp_cyc += 3; exp_fault = 1; done = 1; end
            else begin
              exp_q.push_back('{1'b0, 1'b1, ea, 32'd0});
              wr = ir[20:16]; v = ref_mem[ea[11:2]]; exp_cyc += 5;
            end
          end
          6'h2B: begin
            ea = r[ir[25:21]] + sext(ir[15:0]);
            if (ea[1:0] != 0) begin exp_cyc += 3; exp_fault = 1; done = 1; end
            else begin
              exp_q.push_back('{1'b1, 1'b1, ea, r[ir[20:16]]});
              ref_mem[ea[11:2]] = r[ir[20:16]]; exp_cyc += 4;
            end
          end
          6'h04: begin if (r[ir[25:21]] == r[ir[20:16]]) pc = pc + (sext(ir[15:0]) << 2); exp_cyc += 3; end
          6'h05: begin if (r[ir[25:21]] != r[ir[20:16]]) pc = pc + (sext(ir[15:0]) << 2); exp_cyc += 3; end
          6'h02: begin pc = {pc[31:28], ir[25:0], 2'b00}; exp_cyc += 3; end
          default: begin exp_cyc += 2; exp_fault = 1; done = 1; end
        endcase
        if (wr != 0) r[wr] = v;
      end
    end
    exp_pc = pc;
  endtask

  int          edges, waits;
  logic [31:0] obs_addr[$];
  int          obs_edge[$];

  // mode 0: zero-wait, 1: random waits, 2: three waits on every data access
  task automatic run(input int mode, input bit abort_on_store, input string tag);
    bit          hold, rdy;
    int          wcnt;
    logic [31:0] h_addr, h_wdata;
    logic        h_we;
    txn_t        t;
    rst = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    chk({tag, ".rst_req"}, mem_req, 0);
    chk({tag, ".rst_we"}, mem_we, 0);
    chk({tag, ".rst_addr"}, mem_addr, 0);
    chk({tag, ".rst_wdata"}, mem_wdata, 0);
    chk({tag, ".rst_halted"}, halted, 0);
    chk({tag, ".rst_fault"}, fault, 0);
    chk({tag, ".rst_pc"}, dbg_pc, RESET_PC);
    iss();
    rst = 1'b1; #1;
    edges = 0; waits = 0; wcnt = 0; hold = 0;
    h_addr = 0; h_wdata = 0; h_we = 0;
    obs_addr.delete(); obs_edge.delete();
    while (!halted && edges < 5000) begin
      rdy = 0;
      if (mem_req) begin
        if (hold) begin
          chk({tag, ".hold_addr"}, mem_addr, h_addr);
          chk({tag, ".hold_we"}, mem_we, h_we);
          chk({tag, ".hold_wdata"}, mem_wdata, h_wdata);
        end
        if (exp_q.size() == 0) begin
          chk({tag, ".spurious_req"}, mem_addr, 32'hDEAD_BEEF);
          break;
        end
        t = exp_q[0];
        if (abort_on_store && mem_we) begin
          rst = 1'b0; #1;
          chk({tag, ".abort_req"}, mem_req, 0);
          chk({tag, ".abort_we"}, mem_we, 0);
          chk({tag, ".abort_halted"}, halted, 0);
          return;
        end
        case (mode)
          0:       rdy = 1;
          1:       rdy = ($urandom_range(0, 2) != 0);
          default: rdy = !t.data || wcnt == 3;
        endcase
        if (rdy) begin
          chk({tag, ".addr"}, mem_addr, t.addr);
          chk({tag, ".we"}, mem_we, t.we);
          if (t.we) begin
            chk({tag, ".wdata"}, mem_wdata, t.wdata);
            mem[mem_addr[11:2]] = mem_wdata;
          end
          void'(exp_q.pop_front());
          obs_addr.push_back(mem_addr);
          obs_edge.push_back(edges);
          hold = 0; wcnt = 0;
        end else begin
          waits++; wcnt++; hold = 1;
          h_addr = mem_addr; h_we = mem_we; h_wdata = mem_wdata;
        end
      end else begin
        if (hold) chk({tag, ".req_dropped"}, 0, 1);
        hold = 0;
        rdy = $urandom_range(0, 1);
      end
      mem_ready = rdy;
      @(posedge clk); edges++;
      @(negedge clk); #1;
    end
    mem_ready = 1'b0;
    if (edges >= 5000) chk({tag, ".timeout"}, edges, 0);
    chk({tag, ".halted"}, halted, 1);
    chk({tag, ".cycles"}, edges, exp_cyc + waits);
    chk({tag, ".fault"}, fault, exp_fault);
    chk({tag, ".pc"}, dbg_pc, exp_pc);
    chk({tag, ".pending"}, exp_q.size(), 0);
  endtask

  task automatic gen_random(input int n);
    logic [5:0]  fns [8];
    logic [15:0] off;
    logic [31:0] a;
    fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A};
    clear_mem();
    for (int i = 0; i < n; i++) begin
      a = i * 4;
      off = 16'h0200 + 16'($urandom_range(0, 15) * 4);
      case ($urandom_range(0, 9))
        0, 1: put(a, i_(6'h08, 5'($urandom_range(0, 7)), 5'($urandom_range(1, 7)), 16'($urandom)));
        2, 3, 4, 9: put(a, r_(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                              5'($urandom_range(0, 7)), fns[$urandom_range(0, 7)]));
        5: put(a, i_(6'h2B, 5'd0, 5'($urandom_range(0, 7)), off));
        6: put(a, i_(6'h23, 5'd0, 5'($urandom_range(0, 7)), off));
        7: put(a, i_($urandom_range(0, 1) ? 6'h04 : 6'h05, 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), 16'($urandom_range(0, 2))));
        default: begin
          if ($urandom_range(0, 3) == 0) put(a, i_(6'h23, 5'd0, 5'd1, 16'h0201));
          else put(a, i_(6'h08, 5'd0, 5'($urandom_range(1, 7)), 16'($urandom)));
        end
      endcase
    end
    for (int i = n; i < n + 4; i++) put(i * 4, 32'h0000_000C);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    mem_ready = 1'b0;

    // zero-wait arithmetic then syscall
    clear_mem();
    put(32'h00, i_(6'h08, 5'd0, 5'd1, 16'd5));
    put(32'h04, i_(6'h08, 5'd0, 5'd2, 16'hFFFD));
    put(32'h08, r_(5'd1, 5'd2, 5'd3, 6'h20));
    put(32'h0C, 32'h0000_000C);
    run(0, 0, "arith");
    chk("arith.cycle15", edges + 1, 15);
    chk("arith.pc16", dbg_pc, RESET_PC + 16);

    clear_mem();
    put(32'h00, i_(6'h08, 5'd0, 5'd1, 16'd5));
    put(32'h04, i_(6'h08, 5'd0, 5'd2, 16'hFFFD));
    put(32'h08, r_(5'd1, 5'd2, 5'd3, 6'h20));
    put(32'h0C, i_(6'h2B, 5'd0, 5'd3, 16'h0200));
    put(32'h10, 32'h0000_000C);
    run(1, 0, "arith_st");
    chk("arith_st.r3", mem[128], 32'd2);

    // store/load with three wait states per data access
    clear_mem();
    put(32'h000, {6'h02, 26'h40});
    put(32'h100, i_(6'h08, 5'd0, 5'd1, 16'd5));
    put(32'h104, i_(6'h2B, 5'd0, 5'd1, 16'd8));
    put(32'h108, i_(6'h23, 5'd0, 5'd4, 16'd8));
    put(32'h10C, i_(6'h2B, 5'd0, 5'd4, 16'h0200));
    put(32'h110, 32'h0000_000C);
    run(2, 0, "wait");
    chk("wait.nobs_ok", obs_edge.size() >= 7, 1);
    if (obs_edge.size() >= 7) begin
      chk("wait.sw_cycles", obs_edge[4] - obs_edge[2], 7);
      chk("wait.lw_cycles", obs_edge[6] - obs_edge[4], 8);
      chk("wait.sw_addr", obs_addr[3], 32'd8);
    end
    chk("wait.mem8", mem[2], 32'd5);
    chk("wait.r4", mem[128], 32'd5);

    // branches, jump, slt/sub, r0 write discard
    clear_mem();
    put(32'h00, i_(6'h08, 5'd0, 5'd1, 16'd5));
    put(32'h04, i_(6'h08, 5'd0, 5'd2, 16'hFFFD));
    put(32'h08, r_(5'd2, 5'd1, 5'd5, 6'h2A));
    put(32'h0C, r_(5'd0, 5'd1, 5'd6, 6'h22));
    put(32'h10, i_(6'h04, 5'd1, 5'd1, 16'd2));
    put(32'h14, 32'h0000_000C);
    put(32'h18, 32'h0000_000C);
    put(32'h1C, i_(6'h05, 5'd1, 5'd1, 16'd5));
    put(32'h20, {6'h02, 26'h40});
    put(32'h100, i_(6'h08, 5'd0, 5'd0, 16'd7));
    put(32'h104, i_(6'h2B, 5'd0, 5'd5, 16'h0200));
    put(32'h108, i_(6'h2B, 5'd0, 5'd6, 16'h0204));
    put(32'h10C, i_(6'h2B, 5'd0, 5'd0, 16'h0208));
    put(32'h110, 32'h0000_000C);
    run(1, 0, "branch");
    chk("branch.nobs_ok", obs_addr.size() >= 8, 1);
    if (obs_addr.size() >= 8) begin
      chk("branch.beq_tgt", obs_addr[5], 32'h1C);
      chk("branch.bne_fall", obs_addr[6], 32'h20);
      chk("branch.j_tgt", obs_addr[7], 32'h100);
    end
    chk("branch.slt", mem[128], 32'd1);
    chk("branch.sub", mem[129], 32'hFFFF_FFFB);
    chk("branch.r0", mem[130], 32'd0);

    // faults
    clear_mem();
    put(32'h00, i_(6'h23, 5'd0, 5'd1, 16'd2));
    run(0, 0, "misalign");
    chk("misalign.fault", fault, 1);
    chk("misalign.no_data_req", obs_addr.size(), 1);
    chk("misalign.cycles", edges, 3);

    clear_mem();
    put(32'h00, {6'h3F, 26'h0});
    run(1, 0, "illegal");
    chk("illegal.fault", fault, 1);
    chk("illegal.pc", dbg_pc, RESET_PC + 4);

    // reset while a store is waiting in MEM, then check registers cleared
    clear_mem();
    put(32'h000, {6'h02, 26'h40});
    put(32'h100, i_(6'h08, 5'd0, 5'd1, 16'd5));
    put(32'h104, i_(6'h2B, 5'd0, 5'd1, 16'd8));
    put(32'h108, 32'h0000_000C);
    run(2, 1, "abort");
    clear_mem();
    put(32'h00, i_(6'h2B, 5'd0, 5'd1, 16'h0200));
    put(32'h04, i_(6'h2B, 5'd0, 5'd4, 16'h0204));
    put(32'h08, i_(6'h2B, 5'd0, 5'd5, 16'h0208));
    put(32'h0C, 32'h0000_000C);
    run(0, 0, "post_rst");
    chk("post_rst.first_fetch", obs_addr.size() > 0 ? obs_addr[0] : 32'hFFFF_FFFF, RESET_PC);
    chk("post_rst.r1", mem[128], 32'd0);
    chk("post_rst.r4", mem[129], 32'd0);

    for (int s = 0; s < 9; s++) begin
      gen_random(24);
      run(s % 3, 0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
